// File: rtl/coeff_loader.sv
// coeff_loader: deserialises the framed MSB-first coefficient stream into sequential memory writes
module coeff_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 9,
  parameter int NUM_COEFF = 512
) (
  input  logic              Sclk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Frame,
  input  logic              InputBit,
  output logic              write_enable,
  output logic              mem_frame,
  output logic [ADDR_W-1:0] Write_Address,
  output logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              load_done,
  output logic              sync_error
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_COEFF - 1);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0] bitcnt;
  logic [ADDR_W-1:0] addr;
  logic take, shift, complete, early, done_w;
  assign mem_frame = write_enable;
  // the last word's strobe is the only one issued while already in DONE
  assign done_w = write_enable && state == DONE;
  always_comb begin
    state_nx = state;
    take = 1'b0;
    shift = 1'b0;
    complete = 1'b0;
    early = 1'b0;
    if (Start) state_nx = WAIT_FRAME;
    else begin
      unique case (state)
        WAIT_FRAME: begin
          take = Frame;
          state_nx = Frame ? SHIFT : WAIT_FRAME;
        end
        SHIFT: begin
          take = Frame;
          early = Frame;
          complete = !Frame && bitcnt == '0;
          shift = !Frame && bitcnt != '0;
          state_nx = complete ? (addr == LAST ? DONE : WAIT_FRAME) : SHIFT;
        end
        default: state_nx = state;
      endcase
    end
  end
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      shreg <= '0;
      bitcnt <= '0;
      addr <= '0;
      write_enable <= 1'b0;
      Write_Address <= '0;
      data_in <= '0;
      busy <= 1'b0;
      load_done <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      state <= state_nx;
      write_enable <= complete;
      sync_error <= early;
      if (take) begin
        shreg <= {{(DATA_W-1){1'b0}}, InputBit};
        bitcnt <= CW'(DATA_W - 2);
      end else if (shift) begin
        shreg <= {shreg[DATA_W-2:0], InputBit};
        bitcnt <= bitcnt - CW'(1);
      end
      if (complete) begin
        data_in <= {shreg[DATA_W-2:0], InputBit};
        Write_Address <= addr;
      end
      if (Start) addr <= '0;
      else if (write_enable && addr != LAST) addr <= addr + ADDR_W'(1);
      busy <= Start ? 1'b1 : (done_w ? 1'b0 : busy);
      load_done <= Start ? 1'b0 : (done_w ? 1'b1 : load_done);
    end
  end
endmodule

// File: tb/tb_coeff_loader.sv
// tb_coeff_loader: directed checks of the coefficient loader with a 4-word load
module tb_coeff_loader;
  logic Sclk = 0, Reset_n = 0, Start = 0, Frame = 0, InputBit = 0;
  logic write_enable, mem_frame, busy, load_done, sync_error;
  logic [8:0] Write_Address;
  logic [15:0] data_in;
  int n_chk = 0, n_err = 0, cyc = 0, wr_cnt = 0, n_sync = 0, n_mf = 0, max_addr = 0;
  int f_cyc = 0, base = 0, s0 = 0;
  int wr_cyc[64];
  logic [15:0] mem[4];
  logic [15:0] words[4];

  coeff_loader #(.DATA_W(16), .ADDR_W(9), .NUM_COEFF(4)) dut (
    .Sclk(Sclk), .Reset_n(Reset_n), .Start(Start), .Frame(Frame), .InputBit(InputBit),
    .write_enable(write_enable), .mem_frame(mem_frame), .Write_Address(Write_Address),
    .data_in(data_in), .busy(busy), .load_done(load_done), .sync_error(sync_error)
  );

  always #5 Sclk = ~Sclk;

  always @(negedge Sclk) begin
    cyc++;
    if (sync_error === 1'b1) n_sync++;
    if (mem_frame !== write_enable) n_mf++;
    if (write_enable === 1'b1) begin
      mem[Write_Address[1:0]] = data_in;
      if (int'(Write_Address) > max_addr) max_addr = int'(Write_Address);
      if (wr_cnt < 64) wr_cyc[wr_cnt] = cyc;
      wr_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Sclk);
    #1;
  endtask

  task automatic start_pulse();
    tick();
    Start = 1;
    Frame = 0;
    tick();
    Start = 0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      Frame = (i == 0);
      InputBit = w[15-i];
      if (i == 0) f_cyc = cyc;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_bits(w, 16);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_we", write_enable, 0);
    chk("rst_mf", mem_frame, 0);
    chk("rst_addr", Write_Address, 0);
    chk("rst_data", data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_sync", sync_error, 0);
    Reset_n = 1;
    // no Start yet: frames must be ignored
    for (int k = 0; k < 3; k++) send_word(16'($urandom));
    tick();
    chk("idle_wr", wr_cnt, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", load_done, 0);
    // single word
    start_pulse();
    chk("t1_busy_start", busy, 1);
    send_word(16'hA5C3);
    Frame = 0;
    chk("t1_we_early", write_enable, 0);
    tick();
    chk("t1_we", write_enable, 1);
    chk("t1_mf", mem_frame, 1);
    chk("t1_addr", Write_Address, 0);
    chk("t1_data", data_in, 16'hA5C3);
    chk("t1_busy", busy, 1);
    chk("t1_done", load_done, 0);
    chk("t1_latency", wr_cyc[wr_cnt-1] - f_cyc, 16);
    tick();
    chk("t1_we_off", write_enable, 0);
    // full back-to-back load, restarted while busy
    words = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
    start_pulse();
    base = wr_cnt;
    for (int k = 0; k < 4; k++) send_word(words[k]);
    Frame = 0;
    tick();
    chk("full_we4", write_enable, 1);
    chk("full_addr4", Write_Address, 3);
    chk("full_busy4", busy, 1);
    chk("full_done4", load_done, 0);
    tick();
    chk("full_done", load_done, 1);
    chk("full_busy", busy, 0);
    chk("full_cnt", wr_cnt - base, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("full_mem%0d", k), mem[k], words[k]);
    for (int k = 1; k < 4; k++) chk($sformatf("full_gap%0d", k), wr_cyc[base+k] - wr_cyc[base+k-1], 16);
    send_word(16'hBEEF);
    send_word(16'h0000);
    Frame = 0;
    tick();
    chk("done_nowr", wr_cnt - base, 4);
    chk("done_hold_addr", Write_Address, 3);
    chk("done_hold_data", data_in, 16'h1234);
    chk("done_sticky", load_done, 1);
    // early Frame aborts the partial word
    start_pulse();
    chk("ef_done_clr", load_done, 0);
    s0 = n_sync;
    base = wr_cnt;
    send_bits(16'hFFFF, 9);
    send_word(16'h00FF);
    Frame = 0;
    tick();
    chk("ef_we", write_enable, 1);
    chk("ef_addr", Write_Address, 0);
    chk("ef_data", data_in, 16'h00FF);
    chk("ef_sync", n_sync - s0, 1);
    chk("ef_cnt", wr_cnt - base, 1);
    // restart after 2 words, Start landing on the 2nd strobe
    start_pulse();
    base = wr_cnt;
    send_word(16'h1111);
    send_word(16'h2222);
    start_pulse();
    chk("rs_strobe_kept", wr_cnt - base, 2);
    chk("rs_strobe_addr", Write_Address, 1);
    words = '{16'hCAFE, 16'h0BAD, 16'h7E57, 16'hD00D};
    for (int k = 0; k < 4; k++) send_word(words[k]);
    Frame = 0;
    tick();
    chk("rs_we4", write_enable, 1);
    chk("rs_addr4", Write_Address, 3);
    chk("rs_done_pre", load_done, 0);
    tick();
    chk("rs_done", load_done, 1);
    chk("rs_cnt", wr_cnt - base, 6);
    for (int k = 0; k < 4; k++) chk($sformatf("rs_mem%0d", k), mem[k], words[k]);
    // asynchronous reset mid-word
    start_pulse();
    send_bits(16'h1234, 8);
    #2 Reset_n = 0;
    #1;
    chk("ar_we", write_enable, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", load_done, 0);
    chk("ar_addr", Write_Address, 0);
    chk("ar_data", data_in, 0);
    chk("ar_sync", sync_error, 0);
    base = wr_cnt;
    Frame = 0;
    #3 Reset_n = 1;
    repeat (20) tick();
    chk("ar_nowr", wr_cnt, base);
    start_pulse();
    send_word(16'h5A5A);
    Frame = 0;
    tick();
    chk("ar_we2", write_enable, 1);
    chk("ar_addr2", Write_Address, 0);
    chk("ar_data2", data_in, 16'h5A5A);
    chk("mf_eq_we", n_mf, 0);
    chk("addr_max", max_addr <= 3, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
